// File: rtl/stream_cmd_pkg.sv
// Shared types and constants for the host byte-stream command decoder.
// Latency: none (declarations only). Backpressure: not applicable.
// Holds FSM states, escape token kinds, error codes, escape opcodes and command match.
package stream_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERROR  = 2'd1,
    LOAD   = 2'd2,
    FINISH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TOK_DATA  = 2'd0,
    TOK_ABORT = 2'd1,
    TOK_ACK   = 2'd2,
    TOK_BAD   = 2'd3
  } tok_kind_e;

  typedef struct packed {
    tok_kind_e  kind;
    logic [7:0] dat;
  } tok_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD   = 2'd1;
  localparam logic [1:0] ERR_BAD_ESC   = 2'd2;
  localparam logic [1:0] ERR_LATE_DATA = 2'd3;

  localparam logic [7:0] ESC_ABORT = 8'h00;
  localparam logic [7:0] ESC_ACK   = 8'h01;
  localparam logic [7:0] CMD_MASK  = 8'hC0;
  localparam logic [7:0] CMD_VALUE = 8'h80;

  function automatic logic is_load_cmd(input logic [7:0] b);
    return (b & CMD_MASK) == CMD_VALUE;
  endfunction

endpackage

// File: rtl/stream_escape_decoder.sv
// Escape layer: turns accepted bytes into data/abort/ack/bad tokens.
// Latency: token is combinational with the accepted byte; only the escape flag is stored.
// Backpressure: none of its own; caller presents only bytes it has accepted.
module stream_escape_decoder
  import stream_cmd_pkg::*;
#(
  parameter logic [7:0] ESC_BYTE = 8'hFE
) (
  input  logic       core_clk,
  input  logic       arst_n,
  input  logic       byte_vld,
  input  logic [7:0] byte_dat,
  output logic       tok_vld,
  output tok_t       tok_dat
);

  logic esc_q, esc_d;

  always_comb begin
    esc_d        = esc_q;
    tok_vld      = 1'b0;
    tok_dat.kind = TOK_DATA;
    tok_dat.dat  = byte_dat;
    if (byte_vld) begin
      if (esc_q) begin
        esc_d   = 1'b0;
        tok_vld = 1'b1;
        if (byte_dat == ESC_ABORT)     tok_dat.kind = TOK_ABORT;
        else if (byte_dat == ESC_ACK)  tok_dat.kind = TOK_ACK;
        else if (byte_dat == ESC_BYTE) tok_dat.kind = TOK_DATA;
        else                           tok_dat.kind = TOK_BAD;
      end else if (byte_dat == ESC_BYTE) begin
        esc_d = 1'b1;
      end else begin
        tok_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) esc_q <= 1'b0;
    else         esc_q <= esc_d;
  end

endmodule

// File: rtl/stream_cmd_decoder.sv
// Host stream parser: load command, escapes, frame payload out (trailer sum if STREAM_CMD_DECODER_CHECKSUM_EN).
// Latency: byte accepted at edge N appears on oPIX at N+1; status pulses also at N+1.
// Backpressure: oBYTE_READY = !oPIX_VALID || iPIX_READY, applied to every byte kind.
module stream_cmd_decoder
  import stream_cmd_pkg::*;
#(
  parameter logic [7:0] ESC_BYTE         = 8'hFE,
  parameter int         FRAME_BYTES_LOG2 = 20,
  parameter int         FRAME_IDX_W      = 6,
  parameter int         CNT_W            = FRAME_BYTES_LOG2 + FRAME_IDX_W + 1
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [7:0]             iBYTE_DATA,
  input  logic                   iBYTE_VALID,
  output logic                   oBYTE_READY,
  output logic [7:0]             oPIX_DATA,
  output logic                   oPIX_VALID,
  input  logic                   iPIX_READY,
  output logic [FRAME_IDX_W:0]   oNUM_FRAMES,
  output logic                   oTRIGGER,
  output logic                   oFLUSH,
  output logic                   oBUSY,
  output logic                   oERROR,
  output logic [1:0]             oERR_CODE
);

  localparam int NF_W = FRAME_IDX_W + 1;

  state_e           state_q, state_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [NF_W-1:0]  num_frames_q, num_frames_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, cnt_end;
  logic             pix_vld_q, pix_vld_d;
  logic [7:0]       pix_dat_q, pix_dat_d;
  logic             trigger_q, trigger_d, flush_q, flush_d;
  logic             byte_rdy, byte_fire, tok_vld, push;
  tok_t             tok;
`ifdef STREAM_CMD_DECODER_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
  logic             trl_ok_q, trl_ok_d;
`endif

  assign byte_rdy  = !pix_vld_q || iPIX_READY;
  assign byte_fire = iBYTE_VALID && byte_rdy;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  // Counter carries a spare MSB so a full 2^FRAME_IDX_W-frame target is representable.
  assign cnt_end   = CNT_W'(num_frames_q) << FRAME_BYTES_LOG2;

  stream_escape_decoder #(.ESC_BYTE(ESC_BYTE)) u_esc (
    .core_clk (iCLK),
    .arst_n   (iRST_N),
    .byte_vld (byte_fire),
    .byte_dat (iBYTE_DATA),
    .tok_vld  (tok_vld),
    .tok_dat  (tok)
  );

  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    num_frames_d = num_frames_q;
    cnt_d        = cnt_q;
    pix_vld_d    = pix_vld_q && !iPIX_READY;
    pix_dat_d    = pix_dat_q;
    trigger_d    = 1'b0;
    flush_d      = 1'b0;
    push         = 1'b0;
`ifdef STREAM_CMD_DECODER_CHECKSUM_EN
    sum_d        = sum_q;
    trl_ok_d     = trl_ok_q;
`endif
    if (tok_vld) begin
      case (tok.kind)
        TOK_ABORT: begin
          state_d   = IDLE;
          flush_d   = 1'b1;
          cnt_d     = '0;
          pix_vld_d = 1'b0;
        end
        TOK_BAD: begin
          state_d    = ERROR;
          err_code_d = ERR_BAD_ESC;
        end
        TOK_ACK: begin
          if (state_q == LOAD) begin
            state_d    = ERROR;
            err_code_d = ERR_BAD_ESC;
          end else if (state_q == FINISH) begin
`ifdef STREAM_CMD_DECODER_CHECKSUM_EN
            if (trl_ok_q) state_d = IDLE;
`else
            state_d = IDLE;
`endif
          end
        end
        default: begin
          case (state_q)
            LOAD: begin
              push  = 1'b1;
              cnt_d = cnt_inc;
              if (cnt_inc == cnt_end) state_d = FINISH;
`ifdef STREAM_CMD_DECODER_CHECKSUM_EN
              sum_d = sum_q + tok.dat;
`endif
            end
            FINISH: begin
`ifdef STREAM_CMD_DECODER_CHECKSUM_EN
              if (!trl_ok_q && tok.dat == sum_q) begin
                trl_ok_d = 1'b1;
              end else begin
                state_d    = ERROR;
                err_code_d = ERR_LATE_DATA;
              end
`else
              state_d    = ERROR;
              err_code_d = ERR_LATE_DATA;
`endif
            end
            default: begin
              if (is_load_cmd(tok.dat)) begin
                state_d      = LOAD;
                num_frames_d = NF_W'(tok.dat[FRAME_IDX_W-1:0]) + NF_W'(1);
                cnt_d        = '0;
                flush_d      = 1'b1;
                trigger_d    = 1'b1;
`ifdef STREAM_CMD_DECODER_CHECKSUM_EN
                sum_d        = '0;
                trl_ok_d     = 1'b0;
`endif
              end else begin
                state_d    = ERROR;
                err_code_d = ERR_BAD_CMD;
              end
            end
          endcase
        end
      endcase
    end
    if (push) begin
      pix_vld_d = 1'b1;
      pix_dat_d = tok.dat;
    end
    if (state_d != ERROR) err_code_d = ERR_NONE;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= IDLE;
      err_code_q   <= ERR_NONE;
      num_frames_q <= '0;
      cnt_q        <= '0;
      pix_vld_q    <= 1'b0;
      pix_dat_q    <= '0;
      trigger_q    <= 1'b0;
      flush_q      <= 1'b0;
`ifdef STREAM_CMD_DECODER_CHECKSUM_EN
      sum_q        <= '0;
      trl_ok_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      num_frames_q <= num_frames_d;
      cnt_q        <= cnt_d;
      pix_vld_q    <= pix_vld_d;
      pix_dat_q    <= pix_dat_d;
      trigger_q    <= trigger_d;
      flush_q      <= flush_d;
`ifdef STREAM_CMD_DECODER_CHECKSUM_EN
      sum_q        <= sum_d;
      trl_ok_q     <= trl_ok_d;
`endif
    end
  end

  assign oBYTE_READY = byte_rdy;
  assign oPIX_DATA   = pix_dat_q;
  assign oPIX_VALID  = pix_vld_q;
  assign oNUM_FRAMES = num_frames_q;
  assign oTRIGGER    = trigger_q;
  assign oFLUSH      = flush_q;
  assign oBUSY       = (state_q == LOAD) || (state_q == FINISH);
  assign oERROR      = (state_q == ERROR);
  assign oERR_CODE   = err_code_q;

endmodule
